// File: rtl/sipo_capture.sv
//------------------------------------------------------------------------------
// Module  : sipo_capture
// Purpose : Samples latch output d on each falling edge of en, frames WIDTH
//           bits into a parallel word and offers it on a valid/ready handshake.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sipo_capture #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    input  logic             en,
    input  logic             start,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    localparam int c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt,   w_cnt_nxt;
    logic [WIDTH-1:0]   r_sreg,  w_sreg_nxt;
    logic [WIDTH-1:0]   r_dout,  w_dout_nxt;
    logic               r_ovr,   w_ovr_nxt;
    logic               r_en_q;
    logic               w_smp;
    logic [WIDTH-1:0]   w_shifted;

    // Latch-close event; en_q resetting low keeps en=1 at release from firing.
    assign w_smp = r_en_q & ~en;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_sreg[WIDTH-2:0], d};
        end else begin : g_lsb_first
            assign w_shifted = {d, r_sreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sreg  <= '0;
            r_dout  <= '0;
            r_ovr   <= 1'b0;
            r_en_q  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sreg  <= w_sreg_nxt;
            r_dout  <= w_dout_nxt;
            r_ovr   <= w_ovr_nxt;
            r_en_q  <= en;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sreg_nxt  = r_sreg;
        w_dout_nxt  = r_dout;
        w_ovr_nxt   = r_ovr;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = '0;
                    w_sreg_nxt  = '0;
                    w_ovr_nxt   = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (w_smp) begin
                    w_sreg_nxt = w_shifted;
                    if (r_cnt == c_last) begin
                        w_dout_nxt  = w_shifted;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
            end
            ST_HOLD: begin
                if (w_smp) begin
                    w_ovr_nxt = 1'b1;
                end
                // An accepted start in the handshake cycle wins over the lost sample.
                if (ready) begin
                    if (start) begin
                        w_state_nxt = ST_SHIFT;
                        w_cnt_nxt   = '0;
                        w_sreg_nxt  = '0;
                        w_ovr_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign dout    = r_dout;
    assign valid   = (r_state == ST_HOLD);
    assign busy    = (r_state != ST_IDLE);
    assign overrun = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_sipo_capture.sv
//------------------------------------------------------------------------------
// Module  : tb_sipo_capture
// Purpose : Directed self-checking bench for sipo_capture (MSB- and LSB-first).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sipo_capture;

    logic       clk = 1'b0;
    logic       rst_n, d, en, start, ready;
    logic [7:0] dout_m, dout_l;
    logic       valid_m, busy_m, overrun_m;
    logic       valid_l, busy_l, overrun_l;
    logic       start_noise;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    sipo_capture #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .d(d), .en(en), .start(start), .ready(ready),
        .dout(dout_m), .valid(valid_m), .busy(busy_m), .overrun(overrun_m)
    );

    sipo_capture #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .d(d), .en(en), .start(start), .ready(ready),
        .dout(dout_l), .valid(valid_l), .busy(busy_l), .overrun(overrun_l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One en high/low pair, each level held 2 clk, d stable across the fall.
    task automatic send_bit(input logic b);
        en = 1'b1; d = b; start = start_noise;
        tick();
        start = 1'b0;
        tick();
        en = 1'b0;
        tick();
        tick();
    endtask

    // Send the first n bits of w, w[7] first.
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[7-i]);
    endtask

    // Last bit: returns right after the edge that registers the final event.
    task automatic last_bit(input logic b);
        en = 1'b1; d = b;
        tick();
        tick();
        en = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; d = 1'b0; en = 1'b0; start = 1'b0; ready = 1'b1;
        start_noise = 1'b0;
        tick();
        tick();
        check("rst_dout_m",  dout_m,    8'h00);
        check("rst_dout_l",  dout_l,    8'h00);
        check("rst_valid",   valid_m,   1'b0);
        check("rst_busy",    busy_m,    1'b0);
        check("rst_overrun", overrun_m, 1'b0);
        rst_n = 1'b1;
        tick();

        // Sample event while idle must be ignored.
        send_bit(1'b1);
        check("idle_smp_overrun", overrun_m, 1'b0);
        check("idle_smp_busy",    busy_m,    1'b0);
        check("idle_smp_valid",   valid_m,   1'b0);

        // MSB/LSB frame with start pulses sprinkled through SHIFT.
        pulse_start();
        check("shift_busy", busy_m, 1'b1);
        start_noise = 1'b1;
        send_bits(8'hA6, 7);
        start_noise = 1'b0;
        check("seven_valid",   valid_m,   1'b0);
        check("seven_busy",    busy_m,    1'b1);
        check("seven_overrun", overrun_m, 1'b0);
        last_bit(1'b0);
        check("f1_valid_m", valid_m, 1'b1);
        check("f1_valid_l", valid_l, 1'b1);
        check("f1_dout_m",  dout_m,  8'hA6);
        check("f1_dout_l",  dout_l,  8'h65);
        tick();
        check("f1_pulse_end", valid_m, 1'b0);
        check("f1_busy_end",  busy_m,  1'b0);
        check("f1_dout_keep", dout_m,  8'hA6);
        check("f1_dout_l_keep", dout_l, 8'h65);
        check("f1_overrun",   overrun_m, 1'b0);

        // Backpressure: hold the word for 10 cycles.
        ready = 1'b0;
        pulse_start();
        send_bits(8'hA6, 7);
        last_bit(1'b0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_valid_%0d", i), valid_m, 1'b1);
            check($sformatf("bp_dout_%0d", i),  dout_m,  8'hA6);
            if (i < 9) tick();
        end
        ready = 1'b1;
        tick();
        check("bp_release_valid", valid_m,   1'b0);
        check("bp_overrun",       overrun_m, 1'b0);
        check("bp_dout_keep",     dout_m,    8'hA6);

        // Overrun: sample event lost while holding.
        ready = 1'b0;
        pulse_start();
        send_bits(8'hA6, 7);
        last_bit(1'b0);
        check("ov_pre", overrun_m, 1'b0);
        en = 1'b1; d = 1'b1;
        tick();
        tick();
        en = 1'b0;
        tick();
        check("ov_set",   overrun_m, 1'b1);
        check("ov_dout",  dout_m,    8'hA6);
        check("ov_valid", valid_m,   1'b1);
        tick();
        check("ov_sticky", overrun_m, 1'b1);
        ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("ov_restart_busy",    busy_m,    1'b1);
        check("ov_restart_valid",   valid_m,   1'b0);
        check("ov_restart_overrun", overrun_m, 1'b0);

        // Reset mid-frame after 5 samples, en held high across release.
        send_bits(8'h0F, 5);
        en = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_busy",    busy_m,    1'b0);
        check("mr_valid",   valid_m,   1'b0);
        check("mr_dout",    dout_m,    8'h00);
        check("mr_overrun", overrun_m, 1'b0);
        pulse_start();
        check("mr_start_busy", busy_m, 1'b1);
        d = 1'b1;
        tick();
        en = 1'b0;
        tick();
        tick();
        send_bits(8'hFF, 6);
        check("mr_seven_valid", valid_m, 1'b0);
        check("mr_seven_dout",  dout_m,  8'h00);
        last_bit(1'b1);
        check("mr_valid_done", valid_m, 1'b1);
        check("mr_dout_m",     dout_m,  8'hFF);
        check("mr_dout_l",     dout_l,  8'hFF);
        check("mr_busy_l",     busy_l,  1'b1);
        check("mr_overrun_l",  overrun_l, 1'b0);
        tick();
        check("mr_idle", busy_m, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
